// File: rtl/vscale_sys_arbiter_pkg.sv
// Shared AHB-lite (HASTI) encodings and owner type for the system-port arbiter.
package vscale_sys_arbiter_pkg;

    localparam int HASTI_ADDR_WIDTH = 32;
    localparam int HASTI_BUS_WIDTH  = 32;
    localparam int HASTI_SIZE_WIDTH = 3;

    localparam logic [1:0] HASTI_TRANS_IDLE   = 2'b00;
    localparam logic [1:0] HASTI_TRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HASTI_BURST_SINGLE = 3'b000;
    localparam logic       HASTI_MASTER_NO_LOCK = 1'b0;
    localparam logic [3:0] HASTI_NO_PROT      = 4'b0000;

    // Bit positions inside the two-entry request/grant vectors.
    localparam int REQ_IM = 0;
    localparam int REQ_DM = 1;

    typedef enum logic {
        OWN_IM = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

endpackage

// File: rtl/vscale_sys_arb_prio.sv
// Two-way fixed-priority grant (dm over im) with a saturating im starvation counter.
module vscale_sys_arb_prio
    import vscale_sys_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic [2:0] starve_r;
    logic [2:0] starve_nxt_s;

    // Grant is only handed out in cycles where a new address phase may issue.
    always_comb begin
        gnt = 2'b00;
        if (accept) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (starve_r == LIMIT) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end else begin
            gnt = 2'b00;
        end
    end

    // Count consecutive accepted cycles in which im asked but dm won.
    always_comb begin
        starve_nxt_s = starve_r;
        if (!req[REQ_IM]) begin
            starve_nxt_s = 3'd0;
        end else if (gnt[REQ_IM]) begin
            starve_nxt_s = 3'd0;
        end else if (gnt[REQ_DM]) begin
            starve_nxt_s = (starve_r == LIMIT) ? starve_r : starve_r + 3'd1;
        end else begin
            starve_nxt_s = starve_r;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_r <= 3'd0;
        end else begin
            starve_r <= starve_nxt_s;
        end
    end

endmodule

// File: rtl/vscale_sys_arbiter.sv
// Shares the AHB-lite system-slave port between the im and dm masters,
// tracking the pipelined data-phase owner and honouring slave wait states.
module vscale_sys_arbiter
    import vscale_sys_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = HASTI_ADDR_WIDTH,
    parameter int BUS_WIDTH    = HASTI_BUS_WIDTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        im_req,
    input  logic [ADDR_WIDTH-1:0]       im_addr,
    input  logic                        im_write,
    input  logic [HASTI_SIZE_WIDTH-1:0] im_size,
    input  logic [BUS_WIDTH-1:0]        im_wdata,
    output logic [BUS_WIDTH-1:0]        im_rdata,
    output logic                        im_ready,
    output logic                        im_resp,
    input  logic                        dm_req,
    input  logic [ADDR_WIDTH-1:0]       dm_addr,
    input  logic                        dm_write,
    input  logic [HASTI_SIZE_WIDTH-1:0] dm_size,
    input  logic [BUS_WIDTH-1:0]        dm_wdata,
    output logic [BUS_WIDTH-1:0]        dm_rdata,
    output logic                        dm_ready,
    output logic                        dm_resp,
    output logic [ADDR_WIDTH-1:0]       haddr,
    output logic                        hwrite,
    output logic [HASTI_SIZE_WIDTH-1:0] hsize,
    output logic [1:0]                  htrans,
    output logic [2:0]                  hburst,
    output logic                        hmastlock,
    output logic [3:0]                  hprot,
    output logic [BUS_WIDTH-1:0]        hwdata,
    input  logic [BUS_WIDTH-1:0]        hrdata,
    input  logic                        hready,
    input  logic                        hresp
);

    logic       dp_valid_r;
    owner_e     dp_own_r;
    logic       accept_s;
    logic [1:0] gnt_s;

    // Holding off accept while resetn is low keeps the bus IDLE during reset.
    // An error's first cycle (hready=0) also blocks accept, so no grant is given.
    assign accept_s = resetn & (~dp_valid_r | hready);

    vscale_sys_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk    (clk),
        .resetn (resetn),
        .req    ({dm_req, im_req}),
        .accept (accept_s),
        .gnt    (gnt_s)
    );

    // Address-phase mux driven by the granted master.
    always_comb begin
        haddr  = '0;
        hwrite = 1'b0;
        hsize  = '0;
        htrans = HASTI_TRANS_IDLE;
        if (gnt_s[REQ_DM]) begin
            haddr  = dm_addr;
            hwrite = dm_write;
            hsize  = dm_size;
            htrans = HASTI_TRANS_NONSEQ;
        end else if (gnt_s[REQ_IM]) begin
            haddr  = im_addr;
            hwrite = im_write;
            hsize  = im_size;
            htrans = HASTI_TRANS_NONSEQ;
        end else begin
            htrans = HASTI_TRANS_IDLE;
        end
    end

    // Data-phase owner tracking; an in-flight transfer is dropped on reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dp_valid_r <= 1'b0;
            dp_own_r   <= OWN_IM;
        end else if (accept_s) begin
            dp_valid_r <= |gnt_s;
            dp_own_r   <= gnt_s[REQ_DM] ? OWN_DM : OWN_IM;
        end else begin
            dp_valid_r <= dp_valid_r;
            dp_own_r   <= dp_own_r;
        end
    end

    assign hwdata    = (dp_own_r == OWN_DM) ? dm_wdata : im_wdata;
    assign hburst    = HASTI_BURST_SINGLE;
    assign hmastlock = HASTI_MASTER_NO_LOCK;
    assign hprot     = HASTI_NO_PROT;

    assign im_rdata = hrdata;
    assign dm_rdata = hrdata;

    assign im_ready = (~dp_valid_r | (dp_own_r != OWN_IM) | hready) & (~im_req | gnt_s[REQ_IM]);
    assign dm_ready = (~dp_valid_r | (dp_own_r != OWN_DM) | hready) & (~dm_req | gnt_s[REQ_DM]);

    assign im_resp = hresp & dp_valid_r & (dp_own_r == OWN_IM);
    assign dm_resp = hresp & dp_valid_r & (dp_own_r == OWN_DM);

endmodule

// File: tb/tb_vscale_sys_arbiter.sv
// Directed bench for vscale_sys_arbiter: address-phase issue order is scoreboarded,
// data-phase handshakes and responses are checked cycle by cycle.
module tb_vscale_sys_arbiter;
    import vscale_sys_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int BW = 32;
    localparam logic [31:0] IM_A = 32'h8000_1000;
    localparam logic [31:0] DM_A = 32'h8000_2000;

    logic          clk = 1'b0;
    logic          resetn;
    logic          im_req, im_write, dm_req, dm_write;
    logic [AW-1:0] im_addr, dm_addr, haddr;
    logic [2:0]    im_size, dm_size, hsize, hburst;
    logic [BW-1:0] im_wdata, dm_wdata, im_rdata, dm_rdata, hwdata, hrdata;
    logic          im_ready, im_resp, dm_ready, dm_resp;
    logic          hwrite, hmastlock, hready, hresp;
    logic [1:0]    htrans;
    logic [3:0]    hprot;

    typedef struct {
        logic [31:0] addr;
        logic        write;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    vscale_sys_arbiter #(
        .ADDR_WIDTH   (AW),
        .BUS_WIDTH    (BW),
        .STARVE_LIMIT (4)
    ) dut (
        .clk (clk), .resetn (resetn),
        .im_req (im_req), .im_addr (im_addr), .im_write (im_write), .im_size (im_size),
        .im_wdata (im_wdata), .im_rdata (im_rdata), .im_ready (im_ready), .im_resp (im_resp),
        .dm_req (dm_req), .dm_addr (dm_addr), .dm_write (dm_write), .dm_size (dm_size),
        .dm_wdata (dm_wdata), .dm_rdata (dm_rdata), .dm_ready (dm_ready), .dm_resp (dm_resp),
        .haddr (haddr), .hwrite (hwrite), .hsize (hsize), .htrans (htrans), .hburst (hburst),
        .hmastlock (hmastlock), .hprot (hprot), .hwdata (hwdata), .hrdata (hrdata),
        .hready (hready), .hresp (hresp)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic expect_issue(input logic [31:0] a, input logic w);
        exp_t e;
        e.addr  = a;
        e.write = w;
        exp_q.push_back(e);
    endtask

    // Sample mid-cycle; every NONSEQ must match the next expected address phase.
    task automatic settle();
        exp_t e;
        @(negedge clk);
        if (htrans === HASTI_TRANS_NONSEQ) begin
            if (exp_q.size() == 0) begin
                chk32("sb_unexpected_issue", 32'(htrans), 32'(HASTI_TRANS_IDLE));
            end else begin
                e = exp_q.pop_front();
                chk32("sb_issue_addr", haddr, e.addr);
                chk1("sb_issue_write", hwrite, e.write);
            end
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; hready = 1'b1; hresp = 1'b0; hrdata = '0;
        im_req = 1'b0; im_addr = IM_A; im_write = 1'b0; im_size = 3'd2; im_wdata = '0;
        dm_req = 1'b0; dm_addr = DM_A; dm_write = 1'b0; dm_size = 3'd2; dm_wdata = '0;
        next();

        // Reset state: bus idle, ready mirrors ~req.
        dm_req = 1'b1;
        settle();
        chk32("rst_htrans", 32'(htrans), 32'(HASTI_TRANS_IDLE));
        chk1("rst_dm_ready", dm_ready, 1'b0);
        chk1("rst_im_ready", im_ready, 1'b1);
        chk1("rst_dm_resp", dm_resp, 1'b0);
        chk32("rst_hburst", 32'(hburst), 32'(3'b000));
        next();
        dm_req = 1'b0; resetn = 1'b1;
        settle();
        chk1("idle_im_ready", im_ready, 1'b1);
        chk1("idle_dm_ready", dm_ready, 1'b1);
        next();

        // 1: single dm read.
        dm_req = 1'b1; dm_addr = 32'h8000_0010;
        expect_issue(32'h8000_0010, 1'b0);
        settle();
        chk1("t1_addr_ready", dm_ready, 1'b1);
        next();
        dm_req = 1'b0; hrdata = 32'hCAFE_F00D;
        settle();
        chk32("t1_rdata", dm_rdata, 32'hCAFE_F00D);
        chk1("t1_data_ready", dm_ready, 1'b1);
        chk1("t1_resp", dm_resp, 1'b0);
        next();

        // 2: both masters every cycle; im wins once after four dm wins.
        im_req = 1'b1; im_addr = IM_A; dm_req = 1'b1; dm_addr = DM_A;
        for (int i = 0; i < 10; i++) begin
            expect_issue((i % 5 == 4) ? IM_A : DM_A, 1'b0);
            settle();
            chk1("t2_im_ready", im_ready, (i % 5 == 4));
            chk1("t2_dm_ready", dm_ready, (i % 5 != 4));
            next();
        end
        im_req = 1'b0; dm_req = 1'b0;
        settle();
        next();

        // 3: dm write stretched by three wait states, im queued behind it.
        dm_req = 1'b1; dm_write = 1'b1; dm_addr = 32'h8000_0100;
        expect_issue(32'h8000_0100, 1'b1);
        settle();
        chk1("t3_addr_ready", dm_ready, 1'b1);
        next();
        dm_req = 1'b0; dm_write = 1'b0; dm_wdata = 32'h1234_5678;
        im_req = 1'b1; im_addr = 32'h8000_1100; hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk32("t3_hwdata_wait", hwdata, 32'h1234_5678);
            chk1("t3_dm_ready_wait", dm_ready, 1'b0);
            chk1("t3_im_ready_wait", im_ready, 1'b0);
            next();
        end
        hready = 1'b1;
        expect_issue(32'h8000_1100, 1'b0);
        settle();
        chk32("t3_hwdata_done", hwdata, 32'h1234_5678);
        chk1("t3_dm_ready_done", dm_ready, 1'b1);
        chk1("t3_im_granted", im_ready, 1'b1);
        next();
        im_req = 1'b0; hrdata = 32'h600D_1100;
        settle();
        chk32("t3_im_rdata", im_rdata, 32'h600D_1100);
        chk1("t3_im_data_ready", im_ready, 1'b1);
        next();

        // 4: im read answered with a two-cycle ERROR; dm waits through it.
        im_req = 1'b1; im_addr = 32'h8000_1200;
        expect_issue(32'h8000_1200, 1'b0);
        settle();
        chk1("t4_addr_ready", im_ready, 1'b1);
        next();
        im_req = 1'b0; dm_req = 1'b1; dm_addr = 32'h8000_2200;
        hresp = 1'b1; hready = 1'b0;
        settle();
        chk32("t4_err1_htrans", 32'(htrans), 32'(HASTI_TRANS_IDLE));
        chk1("t4_err1_im_ready", im_ready, 1'b0);
        chk1("t4_err1_dm_ready", dm_ready, 1'b0);
        chk1("t4_err1_dm_resp", dm_resp, 1'b0);
        next();
        hready = 1'b1;
        expect_issue(32'h8000_2200, 1'b0);
        settle();
        chk1("t4_err2_im_resp", im_resp, 1'b1);
        chk1("t4_err2_im_ready", im_ready, 1'b1);
        chk1("t4_err2_dm_resp", dm_resp, 1'b0);
        next();
        dm_req = 1'b0; hresp = 1'b0;
        settle();
        chk1("t4_dm_resp", dm_resp, 1'b0);
        chk1("t4_dm_ready", dm_ready, 1'b1);
        next();

        // 5: back-to-back dm reads, no idle bubble.
        dm_req = 1'b1; dm_addr = 32'h8000_0000;
        expect_issue(32'h8000_0000, 1'b0);
        settle();
        next();
        dm_addr = 32'h8000_0004; hrdata = 32'h1111_0000;
        expect_issue(32'h8000_0004, 1'b0);
        settle();
        chk32("t5_htrans_b2b", 32'(htrans), 32'(HASTI_TRANS_NONSEQ));
        chk32("t5_rdata0", dm_rdata, 32'h1111_0000);
        next();
        dm_req = 1'b0; hrdata = 32'h2222_0004;
        settle();
        chk32("t5_rdata1", dm_rdata, 32'h2222_0004);
        chk1("t5_ready1", dm_ready, 1'b1);
        next();

        // 6: build up starvation, then reset mid data phase.
        im_req = 1'b1; im_addr = IM_A; dm_req = 1'b1; dm_addr = DM_A;
        for (int i = 0; i < 4; i++) begin
            expect_issue(DM_A, 1'b0);
            settle();
            next();
        end
        resetn = 1'b0; hready = 1'b0;
        settle();
        chk32("t6_rst_htrans", 32'(htrans), 32'(HASTI_TRANS_IDLE));
        chk1("t6_rst_im_ready", im_ready, 1'b0);
        chk1("t6_rst_dm_ready", dm_ready, 1'b0);
        chk1("t6_rst_im_resp", im_resp, 1'b0);
        next();
        resetn = 1'b1;
        expect_issue(DM_A, 1'b0);
        settle();
        chk1("t6_post_dm_ready", dm_ready, 1'b1);
        chk1("t6_post_im_ready", im_ready, 1'b0);
        next();
        im_req = 1'b0; dm_req = 1'b0; hready = 1'b1;
        settle();
        next();

        chk32("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
